axi_addr_arbiter: RTL and testbench

AXI_ADDR_ARBITER -- requirements
Module: axi_addr_arbiter

---
 rtl/axi_xbar_pkg.sv | 49 ++++
 rtl/rr_arbiter.sv | 36 +++
 rtl/axi_addr_arbiter.sv | 148 ++++++++++++++
 tb/tb_axi_addr_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_xbar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axi_xbar_pkg                                           |
// | Description : Shared AXI address-entry layout and arbiter types.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package axi_xbar_pkg;

  localparam int AXI_ID_W         = 8;
  localparam int AXI_ADDR_W       = 32;
  localparam int AXI_LEN_W        = 4;
  localparam int AXI_SIZE_W       = 3;
  localparam int AXI_BURST_W      = 2;
  localparam int AXI_ADDR_ENTRY_W = 49;

  localparam int AXI_BURST_OFF = 0;
  localparam int AXI_SIZE_OFF  = AXI_BURST_OFF + AXI_BURST_W;
  localparam int AXI_LEN_OFF   = AXI_SIZE_OFF + AXI_SIZE_W;
  localparam int AXI_ADDR_OFF  = AXI_LEN_OFF + AXI_LEN_W;
  localparam int AXI_ID_OFF    = AXI_ADDR_OFF + AXI_ADDR_W;

  localparam int GNT_FIFO_DEPTH = 4;
  localparam int GNT_IDX_W      = 3;

  typedef struct packed {
    logic [AXI_ID_W-1:0]    id;
    logic [AXI_ADDR_W-1:0]  addr;
    logic [AXI_LEN_W-1:0]   len;
    logic [AXI_SIZE_W-1:0]  size;
    logic [AXI_BURST_W-1:0] burst;
  } axi_addr_entry_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  function automatic axi_addr_entry_t axi_unpack_entry(input logic [AXI_ADDR_ENTRY_W-1:0] raw);
    axi_addr_entry_t e;
    e.id    = raw[AXI_ID_OFF    +: AXI_ID_W];
    e.addr  = raw[AXI_ADDR_OFF  +: AXI_ADDR_W];
    e.len   = raw[AXI_LEN_OFF   +: AXI_LEN_W];
    e.size  = raw[AXI_SIZE_OFF  +: AXI_SIZE_W];
    e.burst = raw[AXI_BURST_OFF +: AXI_BURST_W];
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arbiter                                             |
// | Description : Combinational round-robin pick: first request at or    |
// |               above the pointer, wrapping, as one-hot and index.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = int'(i_ptr) + i;
      if (k >= N) k = k - N;
      if (!o_valid && i_req[k]) begin
        o_valid  = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = IDX_W'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_addr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axi_addr_arbiter                                       |
// | Description : Round-robin address-channel arbiter for one slave      |
// |               port with registered AXI address outputs.              |
// |               AXI_ARB_GNT_FIFO_EN adds a 4-entry grant-order FIFO.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module axi_addr_arbiter
  import axi_xbar_pkg::*;
#(
  parameter int M_CNT = 2,
  parameter int S_IDX = 0
) (
  input  logic                          AXI_CLK_i,
  input  logic                          AXI_RST_i,
  input  logic [M_CNT-1:0]              REQ_VALID_i,
  input  logic [M_CNT*AXI_ADDR_ENTRY_W-1:0] REQ_DATA_i,
  output logic [M_CNT-1:0]              REQ_POP_o,
  output logic [AXI_ID_W-1:0]           S_ID_o,
  output logic [AXI_ADDR_W-1:0]         S_ADDR_o,
  output logic [AXI_LEN_W-1:0]          S_LEN_o,
  output logic [AXI_SIZE_W-1:0]         S_SIZE_o,
  output logic [AXI_BURST_W-1:0]        S_BURST_o,
  output logic                          S_VALID_o,
  input  logic                          S_READY_i,
  output logic [GNT_IDX_W-1:0]          GNT_IDX_o,
  output logic                          GNT_VALID_o,
  input  logic                          GNT_POP_i
);

  localparam int c_IDX_W = $clog2(M_CNT);
  // The valid vector arrives already decoded for this slave.
  localparam int c_unused_s_idx = S_IDX;

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  axi_addr_entry_t   r_entry;
  axi_addr_entry_t   w_entries [M_CNT];
  logic [c_IDX_W-1:0] r_rr_ptr;
  logic [c_IDX_W-1:0] w_rr_ptr_next;
  logic [M_CNT-1:0]  w_gnt;
  logic [c_IDX_W-1:0] w_win_idx;
  logic              w_any_req;
  logic              w_slot_free;
  logic              w_fifo_block;
  logic              w_load;

  generate
    for (genvar m = 0; m < M_CNT; m++) begin : g_unpack
      assign w_entries[m] = axi_unpack_entry(REQ_DATA_i[m*AXI_ADDR_ENTRY_W +: AXI_ADDR_ENTRY_W]);
    end
  endgenerate

  rr_arbiter #(
    .N     (M_CNT),
    .IDX_W (c_IDX_W)
  ) u_rr_arbiter (
    .i_req   (REQ_VALID_i),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_win_idx),
    .o_valid (w_any_req)
  );

  // Output register may be refilled when empty or while being handed off.
  assign w_slot_free   = (r_state == ARB_IDLE) || S_READY_i;
  assign w_load        = w_slot_free && w_any_req && !w_fifo_block && !AXI_RST_i;
  assign REQ_POP_o     = w_load ? w_gnt : '0;
  assign w_rr_ptr_next = (w_win_idx == c_IDX_W'(M_CNT - 1)) ? '0 : w_win_idx + c_IDX_W'(1);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE: if (w_load) w_state_next = ARB_HOLD;
      ARB_HOLD: if (S_READY_i && !w_load) w_state_next = ARB_IDLE;
      default:  w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
    if (AXI_RST_i) begin
      r_state  <= ARB_IDLE;
      r_entry  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_entry  <= w_entries[w_win_idx];
        r_rr_ptr <= w_rr_ptr_next;
      end
    end
  end

  assign S_VALID_o = (r_state == ARB_HOLD);
  assign S_ID_o    = r_entry.id;
  assign S_ADDR_o  = r_entry.addr;
  assign S_LEN_o   = r_entry.len;
  assign S_SIZE_o  = r_entry.size;
  assign S_BURST_o = r_entry.burst;

`ifdef AXI_ARB_GNT_FIFO_EN
  localparam int c_FPTR_W = $clog2(GNT_FIFO_DEPTH);

  logic [GNT_IDX_W-1:0] r_gnt_fifo [GNT_FIFO_DEPTH];
  logic [c_FPTR_W-1:0]  r_gnt_wr_ptr;
  logic [c_FPTR_W-1:0]  r_gnt_rd_ptr;
  logic [c_FPTR_W:0]    r_gnt_cnt;
  logic                 w_gnt_empty;
  logic                 w_gnt_push;
  logic                 w_gnt_pop;

  assign w_gnt_empty  = (r_gnt_cnt == '0);
  // A pop in the same cycle frees the slot the new grant needs.
  assign w_fifo_block = (r_gnt_cnt == (c_FPTR_W+1)'(GNT_FIFO_DEPTH)) && !GNT_POP_i;
  assign w_gnt_push   = w_load;
  assign w_gnt_pop    = GNT_POP_i && (!w_gnt_empty || w_gnt_push);

  always_ff @(posedge AXI_CLK_i) begin
    if (w_gnt_push) r_gnt_fifo[r_gnt_wr_ptr] <= GNT_IDX_W'(w_win_idx);
  end

  always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
    if (AXI_RST_i) begin
      r_gnt_wr_ptr <= '0;
      r_gnt_rd_ptr <= '0;
      r_gnt_cnt    <= '0;
    end else begin
      if (w_gnt_push) r_gnt_wr_ptr <= r_gnt_wr_ptr + c_FPTR_W'(1);
      if (w_gnt_pop)  r_gnt_rd_ptr <= r_gnt_rd_ptr + c_FPTR_W'(1);
      if (w_gnt_push && !w_gnt_pop)      r_gnt_cnt <= r_gnt_cnt + (c_FPTR_W+1)'(1);
      else if (w_gnt_pop && !w_gnt_push) r_gnt_cnt <= r_gnt_cnt - (c_FPTR_W+1)'(1);
    end
  end

  assign GNT_VALID_o = !w_gnt_empty;
  assign GNT_IDX_o   = w_gnt_empty ? '0 : r_gnt_fifo[r_gnt_rd_ptr];
`else
  logic w_unused_gnt_pop;

  assign w_unused_gnt_pop = GNT_POP_i;
  assign w_fifo_block     = 1'b0;
  assign GNT_VALID_o      = 1'b0;
  assign GNT_IDX_o        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_addr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_axi_addr_arbiter                                    |
// | Description : Self-checking bench for axi_addr_arbiter (2 masters).  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_axi_addr_arbiter;

  localparam int M  = 2;
  localparam int EW = 49;

  logic            AXI_CLK_i = 1'b0;
  logic            AXI_RST_i;
  logic [M-1:0]    REQ_VALID_i;
  logic [M*EW-1:0] REQ_DATA_i;
  logic [M-1:0]    REQ_POP_o;
  logic [7:0]      S_ID_o;
  logic [31:0]     S_ADDR_o;
  logic [3:0]      S_LEN_o;
  logic [2:0]      S_SIZE_o;
  logic [1:0]      S_BURST_o;
  logic            S_VALID_o;
  logic            S_READY_i;
  logic [2:0]      GNT_IDX_o;
  logic            GNT_VALID_o;
  logic            GNT_POP_i;

  axi_addr_arbiter #(.M_CNT(M), .S_IDX(0)) dut (
    .AXI_CLK_i   (AXI_CLK_i),
    .AXI_RST_i   (AXI_RST_i),
    .REQ_VALID_i (REQ_VALID_i),
    .REQ_DATA_i  (REQ_DATA_i),
    .REQ_POP_o   (REQ_POP_o),
    .S_ID_o      (S_ID_o),
    .S_ADDR_o    (S_ADDR_o),
    .S_LEN_o     (S_LEN_o),
    .S_SIZE_o    (S_SIZE_o),
    .S_BURST_o   (S_BURST_o),
    .S_VALID_o   (S_VALID_o),
    .S_READY_i   (S_READY_i),
    .GNT_IDX_o   (GNT_IDX_o),
    .GNT_VALID_o (GNT_VALID_o),
    .GNT_POP_i   (GNT_POP_i)
  );

  always #5 AXI_CLK_i = ~AXI_CLK_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one pending slave request, a rotating pointer, a grant queue.
  bit          m_valid;
  logic [48:0] m_entry;
  int          m_ptr;
  int          m_q[$];

  typedef struct {
    logic [1:0]  valid;
    logic        ready;
    logic [1:0]  exp_pop;
    logic        exp_sv;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_entry = '0;
    m_ptr   = 0;
    m_q.delete();
  endtask

  task automatic do_reset();
    AXI_RST_i   = 1'b1;
    REQ_VALID_i = '0;
    S_READY_i   = 1'b0;
    GNT_POP_i   = 1'b0;
    repeat (2) @(posedge AXI_CLK_i);
    #1 AXI_RST_i = 1'b0;
    model_reset();
  endtask

  task automatic set_fixed_data();
    REQ_DATA_i[0*EW +: EW] = {8'h10, 32'h1000_0000, 4'h3, 3'h2, 2'h1};
    REQ_DATA_i[1*EW +: EW] = {8'h21, 32'h2000_0000, 4'h7, 3'h3, 2'h1};
  endtask

  task automatic set_random_data();
    for (int m = 0; m < M; m++) begin
      logic [48:0] t;
      t = {17'($urandom), $urandom};
      REQ_DATA_i[m*EW +: EW] = t;
    end
  endtask

  // Apply one cycle of inputs, compare against the model mid-cycle, then advance.
  task automatic model_step(input logic [M-1:0] v, input logic rdy, input logic gp);
    bit   found;
    int   win;
    bit   load;
    bit   full_block;
    logic [M-1:0] exp_pop;
    REQ_VALID_i = v;
    S_READY_i   = rdy;
    GNT_POP_i   = gp;
    @(negedge AXI_CLK_i);
    found = 0;
    win   = 0;
    for (int i = 0; i < M; i++) begin
      int k;
      k = (m_ptr + i) % M;
      if (!found && v[k]) begin
        found = 1;
        win   = k;
      end
    end
`ifdef AXI_ARB_GNT_FIFO_EN
    full_block = (m_q.size() == 4) && !gp;
`else
    full_block = 0;
`endif
    load    = (!m_valid || rdy) && found && !full_block;
    exp_pop = load ? M'(1 << win) : '0;
    chk("pop", 64'(REQ_POP_o), 64'(exp_pop));
    chk("s_valid", 64'(S_VALID_o), 64'(m_valid));
    if (m_valid) chk("s_entry", 64'({S_ID_o, S_ADDR_o, S_LEN_o, S_SIZE_o, S_BURST_o}), 64'(m_entry));
`ifdef AXI_ARB_GNT_FIFO_EN
    chk("gnt_valid", 64'(GNT_VALID_o), 64'(m_q.size() != 0));
    chk("gnt_idx", 64'(GNT_IDX_o), (m_q.size() != 0) ? 64'(m_q[0]) : 64'd0);
`else
    chk("gnt_valid", 64'(GNT_VALID_o), 64'd0);
    chk("gnt_idx", 64'(GNT_IDX_o), 64'd0);
`endif
    if (load) begin
      m_valid = 1'b1;
      m_entry = REQ_DATA_i[win*EW +: EW];
      m_ptr   = (win + 1) % M;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
`ifdef AXI_ARB_GNT_FIFO_EN
    if (load) m_q.push_back(win);
    if (gp && m_q.size() != 0) void'(m_q.pop_front());
`endif
    @(posedge AXI_CLK_i);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b01, 1'b1, 2'b01, 1'b0, 32'h0};
    tbl[1]  = '{2'b11, 1'b1, 2'b10, 1'b1, 32'h1000_0000};
    tbl[2]  = '{2'b11, 1'b1, 2'b01, 1'b1, 32'h2000_0000};
    tbl[3]  = '{2'b11, 1'b1, 2'b10, 1'b1, 32'h1000_0000};
    tbl[4]  = '{2'b11, 1'b0, 2'b00, 1'b1, 32'h2000_0000};
    tbl[5]  = '{2'b00, 1'b1, 2'b00, 1'b1, 32'h2000_0000};
    tbl[6]  = '{2'b00, 1'b1, 2'b00, 1'b0, 32'h0};
    tbl[7]  = '{2'b10, 1'b0, 2'b10, 1'b0, 32'h0};
    tbl[8]  = '{2'b10, 1'b1, 2'b10, 1'b1, 32'h2000_0000};
    tbl[9]  = '{2'b00, 1'b1, 2'b00, 1'b1, 32'h2000_0000};
    tbl[10] = '{2'b00, 1'b0, 2'b00, 1'b0, 32'h0};

    REQ_DATA_i = '0;
    do_reset();

    // Reset state
    @(negedge AXI_CLK_i);
    chk("rst_s_valid", 64'(S_VALID_o), 64'd0);
    chk("rst_s_fields", 64'({S_ID_o, S_ADDR_o, S_LEN_o, S_SIZE_o, S_BURST_o}), 64'd0);
    chk("rst_pop", 64'(REQ_POP_o), 64'd0);
    chk("rst_gnt_valid", 64'(GNT_VALID_o), 64'd0);
    chk("rst_gnt_idx", 64'(GNT_IDX_o), 64'd0);
    @(posedge AXI_CLK_i);
    #1;

    // Directed table: first-grant latency, alternation, hold, idle ready, single requester
    set_fixed_data();
    for (int i = 0; i < 11; i++) begin
      REQ_VALID_i = tbl[i].valid;
      S_READY_i   = tbl[i].ready;
      GNT_POP_i   = 1'b0;
      @(negedge AXI_CLK_i);
      chk($sformatf("tbl%0d_pop", i), 64'(REQ_POP_o), 64'(tbl[i].exp_pop));
      chk($sformatf("tbl%0d_s_valid", i), 64'(S_VALID_o), 64'(tbl[i].exp_sv));
      if (tbl[i].exp_sv) chk($sformatf("tbl%0d_s_addr", i), 64'(S_ADDR_o), 64'(tbl[i].exp_addr));
      @(posedge AXI_CLK_i);
      #1;
    end

    // Stall in HOLD while request data churns
    do_reset();
    set_fixed_data();
    model_step(2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      set_random_data();
      model_step(2'b11, 1'b0, 1'b0);
    end
    model_step(2'b11, 1'b1, 1'b0);
    model_step(2'b00, 1'b1, 1'b0);

    // Reset while a request is held
    do_reset();
    set_fixed_data();
    model_step(2'b10, 1'b0, 1'b0);
    REQ_VALID_i = 2'b11;
    AXI_RST_i   = 1'b1;
    #1;
    chk("midrst_s_valid", 64'(S_VALID_o), 64'd0);
    chk("midrst_pop", 64'(REQ_POP_o), 64'd0);
    @(posedge AXI_CLK_i);
    #1 AXI_RST_i = 1'b0;
    model_reset();
    model_step(2'b11, 1'b1, 1'b0);
    model_step(2'b11, 1'b1, 1'b0);

`ifdef AXI_ARB_GNT_FIFO_EN
    // Grant FIFO fills after four grants, one pop lets the fifth in
    do_reset();
    set_fixed_data();
    for (int i = 0; i < 5; i++) model_step(2'b11, 1'b1, 1'b0);
    chk("fifo_stall_pop", 64'(REQ_POP_o), 64'd0);
    model_step(2'b11, 1'b1, 1'b1);
    model_step(2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) model_step(2'b00, 1'b1, 1'b1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_random_data();
      model_step(M'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
